// File: rtl/mbus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// State encoding, grant encodings, statistics selectors and a saturating-add helper.
package mbus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam logic [1:0] STAT_M0_BEATS = 2'd0;
  localparam logic [1:0] STAT_M1_BEATS = 2'd1;
  localparam logic [1:0] STAT_WAITS    = 2'd2;
  localparam logic [1:0] STAT_FORCED   = 2'd3;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] val, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, val} + {31'b0, inc};
    return sum[32] ? 32'hffff_ffff : sum[31:0];
  endfunction

endpackage

// File: rtl/mbus_rr_pick.sv
// Round-robin choice between two requesters; a tie goes to the master that did not own last.
// pick = 0 selects m0, pick = 1 selects m1; pick_valid is low when neither requests.
module mbus_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic pick_valid,
  output logic pick
);

  always_comb begin
    pick_valid = req0 | req1;
    pick       = (req0 & req1) ? ~last_owner : req1;
  end

endmodule

// File: rtl/mbus_arbiter.sv
// Two-master memory bus arbiter: round-robin ownership with a burst cap under contention.
// Define MBUS_ARBITER_STATS_EN to build the saturating beat/wait/handover counters.
module mbus_arbiter
  import mbus_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_SIZE = 32,
  parameter int BURST_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_req,
  input  logic [ADDR_SIZE-1:0] m0_aout,
  input  logic [WIDTH-1:0]     m0_dout,
  input  logic                 m0_wen,
  output logic [WIDTH-1:0]     m0_din,
  output logic                 m0_ack,
  input  logic                 m1_req,
  input  logic [ADDR_SIZE-1:0] m1_aout,
  input  logic [WIDTH-1:0]     m1_dout,
  input  logic                 m1_wen,
  output logic [WIDTH-1:0]     m1_din,
  output logic                 m1_ack,
  output logic [ADDR_SIZE-1:0] mem_aout,
  output logic [WIDTH-1:0]     mem_dout,
  output logic                 mem_wen,
  input  logic [WIDTH-1:0]     mem_din,
  input  logic                 mem_ready,
  output logic [1:0]           gnt,
  input  logic [1:0]           stat_sel,
  output logic [31:0]          stat_out
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(BURST_MAX);

  state_t             state, state_nxt;
  logic               last_owner, last_nxt;
  logic [CNT_W-1:0]   beat_cnt, cnt_nxt;
  logic [CNT_W:0]     beat_inc;
  logic               own_is1, own_req, oth_req;
  logic               pick_valid, pick;
  logic               forced_ho;

  // While owning, the owner's own request is masked so an aborted beat hands over per the idle rule.
  mbus_rr_pick u_rr_pick (
    .req0       (m0_req & (state != ST_OWN0)),
    .req1       (m1_req & (state != ST_OWN1)),
    .last_owner (last_owner),
    .pick_valid (pick_valid),
    .pick       (pick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_nxt;
      beat_cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last_owner;
    cnt_nxt   = beat_cnt;
    forced_ho = 1'b0;
    gnt       = GNT_NONE;
    mem_aout  = '0;
    mem_dout  = '0;
    mem_wen   = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_din    = mem_din;
    m1_din    = mem_din;
    own_is1   = (state == ST_OWN1);
    own_req   = own_is1 ? m1_req : m0_req;
    oth_req   = own_is1 ? m0_req : m1_req;
    beat_inc  = {1'b0, beat_cnt} + {{CNT_W{1'b0}}, 1'b1};

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (pick_valid) state_nxt = pick ? ST_OWN1 : ST_OWN0;
      end
      ST_OWN0, ST_OWN1: begin
        gnt      = own_is1 ? GNT_M1 : GNT_M0;
        mem_aout = own_is1 ? m1_aout : m0_aout;
        mem_dout = own_is1 ? m1_dout : m0_dout;
        mem_wen  = own_is1 ? m1_wen : m0_wen;
        m0_ack   = ~own_is1 & m0_req & mem_ready;
        m1_ack   = own_is1 & m1_req & mem_ready;
        if (!own_req) begin
          cnt_nxt   = '0;
          state_nxt = pick_valid ? (pick ? ST_OWN1 : ST_OWN0) : ST_IDLE;
        end else if (mem_ready) begin
          last_nxt = own_is1;
          if (oth_req && (beat_inc >= CAP)) begin
            state_nxt = own_is1 ? ST_OWN0 : ST_OWN1;
            cnt_nxt   = '0;
            forced_ho = 1'b1;
          end else begin
            // Saturate so an uncontested owner never wraps the run length.
            cnt_nxt = (beat_inc >= CAP) ? CAP[CNT_W-1:0] : beat_inc[CNT_W-1:0];
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (!reset) begin
      gnt     = GNT_NONE;
      mem_wen = 1'b0;
      m0_ack  = 1'b0;
      m1_ack  = 1'b0;
    end
  end

`ifdef MBUS_ARBITER_STATS_EN
  logic [31:0] cnt_m0, cnt_m1, cnt_wait, cnt_forced;
  logic [1:0]  wait_inc;

  always_comb begin
    wait_inc = {1'b0, m0_req & ~m0_ack} + {1'b0, m1_req & ~m1_ack};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_m0     <= '0;
      cnt_m1     <= '0;
      cnt_wait   <= '0;
      cnt_forced <= '0;
    end else begin
      cnt_m0     <= sat_add(cnt_m0, {1'b0, m0_ack});
      cnt_m1     <= sat_add(cnt_m1, {1'b0, m1_ack});
      cnt_wait   <= sat_add(cnt_wait, wait_inc);
      cnt_forced <= sat_add(cnt_forced, {1'b0, forced_ho});
    end
  end

  always_comb begin
    case (stat_sel)
      STAT_M0_BEATS: stat_out = cnt_m0;
      STAT_M1_BEATS: stat_out = cnt_m1;
      STAT_WAITS:    stat_out = cnt_wait;
      STAT_FORCED:   stat_out = cnt_forced;
      default:       stat_out = '0;
    endcase
  end
`else
  logic unused_stats;
  assign unused_stats = ^{stat_sel, forced_ho};
  assign stat_out     = '0;
`endif

endmodule

// File: tb/tb_mbus_arbiter.sv
// Directed scenarios plus randomized traffic for mbus_arbiter, checked against an
// ownership-level reference model; statistics are checked when MBUS_ARBITER_STATS_EN is set.
module tb_mbus_arbiter;
  localparam int W    = 32;
  localparam int A    = 32;
  localparam int BMAX = 4;

  logic clk = 1'b0;
  logic reset;
  logic m0_req, m0_wen, m0_ack, m1_req, m1_wen, m1_ack;
  logic [A-1:0] m0_aout, m1_aout, mem_aout;
  logic [W-1:0] m0_dout, m1_dout, m0_din, m1_din, mem_dout, mem_din;
  logic mem_wen, mem_ready;
  logic [1:0] gnt, stat_sel;
  logic [31:0] stat_out;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, who owned last, beats in the current run.
  int m_owner, m_last, m_run;
  int st_beats[2];
  int st_waits, st_forced;
  bit last_ack[2];
  int scen_ack[2];

  mbus_arbiter #(.WIDTH(W), .ADDR_SIZE(A), .BURST_MAX(BMAX)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_aout(m0_aout), .m0_dout(m0_dout), .m0_wen(m0_wen),
    .m0_din(m0_din), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_aout(m1_aout), .m1_dout(m1_dout), .m1_wen(m1_wen),
    .m1_din(m1_din), .m1_ack(m1_ack),
    .mem_aout(mem_aout), .mem_dout(mem_dout), .mem_wen(mem_wen),
    .mem_din(mem_din), .mem_ready(mem_ready),
    .gnt(gnt), .stat_sel(stat_sel), .stat_out(stat_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check combinational outputs for the current inputs, advance the model, cross one edge.
  task automatic step();
    bit r0, r1, ack0, ack1, ro, rt;
    logic [1:0] eg;
    int o;
    #3;
    r0 = m0_req; r1 = m1_req;
    ack0 = 0; ack1 = 0; eg = 2'b00;
    if (reset && m_owner >= 0) begin
      eg   = (m_owner == 1) ? 2'b10 : 2'b01;
      ack0 = (m_owner == 0) && r0 && mem_ready;
      ack1 = (m_owner == 1) && r1 && mem_ready;
    end
    chk("gnt", {30'b0, gnt}, {30'b0, eg});
    chk("m0_ack", {31'b0, m0_ack}, {31'b0, ack0});
    chk("m1_ack", {31'b0, m1_ack}, {31'b0, ack1});
    if (!reset || m_owner < 0) chk("mem_wen_off", {31'b0, mem_wen}, 32'd0);
    else begin
      chk("mem_wen", {31'b0, mem_wen}, {31'b0, (m_owner == 1) ? m1_wen : m0_wen});
      chk("mem_aout", mem_aout, (m_owner == 1) ? m1_aout : m0_aout);
      chk("mem_dout", mem_dout, (m_owner == 1) ? m1_dout : m0_dout);
    end
    if (reset && m_owner < 0) chk("idle_aout", mem_aout, 32'd0);
    if (ack0) chk("m0_din", m0_din, mem_din);
    if (ack1) chk("m1_din", m1_din, mem_din);

    if (!reset) begin
      st_beats[0] = 0; st_beats[1] = 0; st_waits = 0; st_forced = 0;
      m_owner = -1; m_last = 1; m_run = 0;
    end else begin
      st_beats[0] += int'(ack0);
      st_beats[1] += int'(ack1);
      st_waits += int'(r0 && !ack0) + int'(r1 && !ack1);
      if (m_owner < 0) begin
        if (r0 && r1) m_owner = 1 - m_last;
        else if (r0) m_owner = 0;
        else if (r1) m_owner = 1;
        m_run = 0;
      end else begin
        o  = m_owner;
        ro = (o == 1) ? r1 : r0;
        rt = (o == 1) ? r0 : r1;
        if (!ro) begin
          m_owner = rt ? 1 - o : -1;
          m_run = 0;
        end else if (mem_ready) begin
          m_last = o;
          m_run++;
          if (rt && m_run >= BMAX) begin
            m_owner = 1 - o;
            m_run = 0;
            st_forced++;
          end
        end
      end
    end
    last_ack[0] = ack0; last_ack[1] = ack1;
    scen_ack[0] += int'(ack0); scen_ack[1] += int'(ack1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
    int exp_v[4];
    exp_v[0] = st_beats[0]; exp_v[1] = st_beats[1]; exp_v[2] = st_waits; exp_v[3] = st_forced;
    for (int s = 0; s < 4; s++) begin
      stat_sel = 2'(s);
      #1;
`ifdef MBUS_ARBITER_STATS_EN
      chk($sformatf("%s_stat%0d", tag, s), stat_out, 32'(exp_v[s]));
`else
      chk($sformatf("%s_stat%0d_zero", tag, s), stat_out, 32'd0);
`endif
    end
  endtask

  task automatic rand_inputs();
    reset     = ($urandom_range(0, 199) != 0);
    mem_ready = ($urandom_range(0, 3) != 0);
    mem_din   = $urandom;
    if (!m0_req || last_ack[0]) begin
      m0_req = ($urandom_range(0, 3) != 0);
      m0_aout = $urandom; m0_dout = $urandom; m0_wen = 1'($urandom_range(0, 1));
    end
    if (!m1_req || last_ack[1]) begin
      m1_req = ($urandom_range(0, 3) != 0);
      m1_aout = $urandom; m1_dout = $urandom; m1_wen = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    bit done;
    reset = 1'b0; stat_sel = 2'd0;
    m0_req = 0; m0_aout = '0; m0_dout = '0; m0_wen = 0;
    m1_req = 0; m1_aout = '0; m1_dout = '0; m1_wen = 0;
    mem_din = '0; mem_ready = 0;
    m_owner = -1; m_last = 1; m_run = 0;
    st_beats[0] = 0; st_beats[1] = 0; st_waits = 0; st_forced = 0;
    last_ack[0] = 0; last_ack[1] = 0; scen_ack[0] = 0; scen_ack[1] = 0;
    @(posedge clk); #1;
    step();
    step();
    chk("reset_gnt", {30'b0, gnt}, 32'd0);

    // Single requester: grant after one cycle, ack every cycle.
    reset = 1'b1;
    m0_req = 1; m0_aout = 32'h100; m0_dout = 32'h11; mem_ready = 1; mem_din = 32'hA5A5_0001;
    step();
    chk("t1_gnt", {30'b0, gnt}, 32'd1);
    chk("t1_aout", mem_aout, 32'h100);
    for (int i = 0; i < 6; i++) step();

    // Store beat stalled, then reset mid-beat; first tie after release goes to m0.
    m0_req = 0; step(); step();
    m0_req = 1; m0_wen = 1; m0_dout = 32'hDEAD_BEEF; mem_ready = 0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("t4_wen_rst", {31'b0, mem_wen}, 32'd0);
    chk("t4_gnt_rst", {30'b0, gnt}, 32'd0);
    step();
    reset = 1'b1; m0_wen = 0; m1_req = 1; m1_aout = 32'h200; m1_wen = 1;
    step();
    chk("t4_tie_m0", {30'b0, gnt}, 32'd1);

    // m0 drops its request mid-beat with m1 pending: no ack, handover.
    step();
    m0_req = 0;
    step();
    chk("t5_gnt_m1", {30'b0, gnt}, 32'd2);

    // m1 stalls three cycles while m0 requests; no preemption.
    m0_req = 1; m0_aout = 32'h300;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold", {30'b0, gnt}, 32'd2);
    end
    mem_ready = 1; mem_din = 32'hCAFE_F00D;
    #1;
    chk("t3_ack", {31'b0, m1_ack}, 32'd1);
    chk("t3_din", m1_din, 32'hCAFE_F00D);
    step();

    // Sustained contention: 12 beats each, bursts of BURST_MAX, then counters.
    m0_req = 0; m1_req = 0; m0_wen = 0; m1_wen = 0;
    reset = 1'b0;
    step();
    reset = 1'b1; m0_req = 1; m1_req = 1; mem_ready = 1;
    scen_ack[0] = 0; scen_ack[1] = 0;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      mem_din = $urandom;
      step();
      if (scen_ack[0] >= 12) m0_req = 0;
      if (scen_ack[1] >= 12) begin m1_req = 0; done = 1; end
    end
    chk("t2_done", {31'b0, done}, 32'd1);
    chk("t2_m0_beats", 32'(scen_ack[0]), 32'd12);
`ifdef MBUS_ARBITER_STATS_EN
    stat_sel = 2'd0; #1; chk("t6_m0", stat_out, 32'd12);
    stat_sel = 2'd1; #1; chk("t6_m1", stat_out, 32'd12);
    stat_sel = 2'd3; #1; chk("t6_forced", stat_out, 32'd5);
`endif
    check_stats("t6");
    step();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      rand_inputs();
      step();
    end
    reset = 1'b1;
    check_stats("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
